// File: rtl/cond_pkg.sv
// Shared constants for the conditional-execution path: condition codes,
// NZCV bit positions and the FlagW field layout.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagW_E bit positions: NZ group and CV group
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Pure combinational condition evaluator: (Cond, Flags) -> pass.
// Also used by the branch predictor's resolve check.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (Cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: NZCV flag register, condition gating of the
// Execute-stage enables. Optional perf counters under COND_PERF_CNT_EN.
module cond_unit
    import cond_pkg::*;
(
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       Stall_E,
    input  logic       Flush_E,
    input  logic       Valid_E,
    input  logic [3:0] Cond_E,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW_E,
    input  logic       PCS_E,
    input  logic       RegW_E,
    input  logic       MemW_E,
    input  logic       NoWrite_E,
    output logic       CondEx_E,
    output logic [3:0] Flags,
    output logic       C_in,
    output logic       PCSrc_M,
    output logic       RegWrite_M,
    output logic       MemWrite_M
`ifdef COND_PERF_CNT_EN
    ,
    output logic [31:0] ExecCount,
    output logic [31:0] SkipCount
`endif
);

    logic [3:0] flags_q;
    logic       pass;
    logic       flag_update;

    cond_check u_cond_check (
        .Cond  (Cond_E),
        .Flags (flags_q),
        .pass  (pass)
    );

    // Condition is judged on the stored flags, never on in-flight ALUFlags
    assign CondEx_E    = Valid_E & pass & ~Flush_E;
    assign flag_update = CondEx_E & ~Stall_E;

    assign Flags = flags_q;
    assign C_in  = flags_q[FLAG_C];

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            flags_q <= 4'b0000;
        end else if (flag_update) begin
            if (FlagW_E[FLAGW_NZ]) begin
                flags_q[FLAG_N] <= ALUFlags[FLAG_N];
                flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW_E[FLAGW_CV]) begin
                flags_q[FLAG_C] <= ALUFlags[FLAG_C];
                flags_q[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    // Flush outranks stall: a flushed slot always leaves a bubble behind
    always_ff @(posedge CLK) begin
        if (!nRESET || Flush_E) begin
            PCSrc_M    <= 1'b0;
            RegWrite_M <= 1'b0;
            MemWrite_M <= 1'b0;
        end else if (!Stall_E) begin
            PCSrc_M    <= PCS_E & CondEx_E;
            RegWrite_M <= RegW_E & ~NoWrite_E & CondEx_E;
            MemWrite_M <= MemW_E & CondEx_E;
        end
    end

`ifdef COND_PERF_CNT_EN
    logic [31:0] exec_count;
    logic [31:0] skip_count;

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            exec_count <= 32'd0;
            skip_count <= 32'd0;
        end else if (!Stall_E && Valid_E && !Flush_E) begin
            if (pass) begin
                exec_count <= exec_count + 32'd1;
            end else begin
                skip_count <= skip_count + 32'd1;
            end
        end
    end

    assign ExecCount = exec_count;
    assign SkipCount = skip_count;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed + randomized bench for cond_unit against an abstract flag/enable model.
// Perf-counter checks are compiled in when COND_PERF_CNT_EN is defined.
module tb_cond_unit;

    logic       CLK = 1'b0;
    logic       nRESET;
    logic       Stall_E, Flush_E, Valid_E;
    logic [3:0] Cond_E, ALUFlags;
    logic [1:0] FlagW_E;
    logic       PCS_E, RegW_E, MemW_E, NoWrite_E;
    logic       CondEx_E, C_in, PCSrc_M, RegWrite_M, MemWrite_M;
    logic [3:0] Flags;
`ifdef COND_PERF_CNT_EN
    logic [31:0] ExecCount, SkipCount;
    logic [31:0] m_exec, m_skip;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [3:0] m_flags;
    logic       m_pc, m_rw, m_mw;
    logic [3:0] saved_flags;

    always #5 CLK = ~CLK;

    cond_unit dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .Stall_E    (Stall_E),
        .Flush_E    (Flush_E),
        .Valid_E    (Valid_E),
        .Cond_E     (Cond_E),
        .ALUFlags   (ALUFlags),
        .FlagW_E    (FlagW_E),
        .PCS_E      (PCS_E),
        .RegW_E     (RegW_E),
        .MemW_E     (MemW_E),
        .NoWrite_E  (NoWrite_E),
        .CondEx_E   (CondEx_E),
        .Flags      (Flags),
        .C_in       (C_in),
        .PCSrc_M    (PCSrc_M),
        .RegWrite_M (RegWrite_M),
        .MemWrite_M (MemWrite_M)
`ifdef COND_PERF_CNT_EN
        ,
        .ExecCount  (ExecCount),
        .SkipCount  (SkipCount)
`endif
    );

    // Reference: odd codes are the negation of the even code below them
    function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
        int n, z, c, v;
        int base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = (c == 1 && z == 0) ? 1 : 0;
            3'd5:    base = (n == v) ? 1 : 0;
            3'd6:    base = (z == 0 && n == v) ? 1 : 0;
            default: base = 1;
        endcase
        return (base != 0) ^ cond[0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic valid, input logic [3:0] cond, input logic [3:0] aluf,
                         input logic [1:0] flagw, input logic pcs, input logic regw,
                         input logic memw, input logic nowrite);
        Valid_E   = valid;
        Cond_E    = cond;
        ALUFlags  = aluf;
        FlagW_E   = flagw;
        PCS_E     = pcs;
        RegW_E    = regw;
        MemW_E    = memw;
        NoWrite_E = nowrite;
    endtask

    task automatic drive_random();
        drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // One clock: check CondEx_E before the edge, advance the model, check state after
    task automatic tick();
        logic ce, p;
        #1;
        p  = ref_pass(Cond_E, m_flags);
        ce = Valid_E && p && !Flush_E;
        if (nRESET) check("condex", CondEx_E, ce);
        @(posedge CLK);
        if (!nRESET) begin
            m_flags = 4'b0000;
            {m_pc, m_rw, m_mw} = 3'b000;
`ifdef COND_PERF_CNT_EN
            m_exec = 0; m_skip = 0;
`endif
        end else if (Flush_E) begin
            {m_pc, m_rw, m_mw} = 3'b000;
        end else if (!Stall_E) begin
            if (ce && FlagW_E[1]) m_flags[3:2] = ALUFlags[3:2];
            if (ce && FlagW_E[0]) m_flags[1:0] = ALUFlags[1:0];
            m_pc = PCS_E && ce;
            m_rw = RegW_E && !NoWrite_E && ce;
            m_mw = MemW_E && ce;
`ifdef COND_PERF_CNT_EN
            if (Valid_E && p)  m_exec = m_exec + 32'd1;
            if (Valid_E && !p) m_skip = m_skip + 32'd1;
`endif
        end
        #1;
        check("flags", Flags, m_flags);
        check("c_in", C_in, m_flags[1]);
        check("pcsrc_m", PCSrc_M, m_pc);
        check("regwrite_m", RegWrite_M, m_rw);
        check("memwrite_m", MemWrite_M, m_mw);
`ifdef COND_PERF_CNT_EN
        check("exec_count", ExecCount, m_exec);
        check("skip_count", SkipCount, m_skip);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRESET = 1'b0; Stall_E = 1'b0; Flush_E = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        m_flags = 4'b0000; {m_pc, m_rw, m_mw} = 3'b000;
`ifdef COND_PERF_CNT_EN
        m_exec = 0; m_skip = 0;
`endif
        repeat (2) @(posedge CLK);
        #1;
        check("reset_flags", Flags, 4'b0000);
        check("reset_c_in", C_in, 1'b0);
        check("reset_m", {PCSrc_M, RegWrite_M, MemWrite_M}, 3'b000);
        nRESET = 1'b1;

        // First instruction after reset: AL always executes
        drive(1'b1, 4'hE, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check("first_condex", CondEx_E, 1'b1);
        tick();

        // CMP sets Z, the following BEQ sees it one cycle later
        drive(1'b1, 4'hE, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check("cmp_regwrite", RegWrite_M, 1'b0);
        drive(1'b1, 4'h0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("beq_flags", Flags, 4'b0100);
        #1 check("beq_condex", CondEx_E, 1'b1);
        tick();
        check("beq_pcsrc", PCSrc_M, 1'b1);

        // Partial update: only N,Z reloaded
        drive(1'b1, 4'hE, 4'b1010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'hE, 4'b0101, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("partial", Flags, 4'b0110);

        // Full condition sweep on every stored flag value
        for (int f = 0; f < 16; f++) begin
            drive(1'b1, 4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            for (int c = 0; c < 16; c++) begin
                drive(1'b1, 4'(c), 4'($urandom_range(0, 15)), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
                #1 check("sweep", CondEx_E, ref_pass(4'(c), 4'(f)));
                if (c == 15) check("never", CondEx_E, 1'b0);
            end
        end
        drive(1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("invalid", CondEx_E, 1'b0);

        // Stall holds flags and enables for three cycles
        drive(1'b1, 4'hE, 4'b1001, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        saved_flags = m_flags;
        Stall_E = 1'b1;
        repeat (3) begin
            drive(1'b1, 4'hE, 4'($urandom_range(0, 15)), 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
        end
        check("stall_flags", Flags, saved_flags);
        check("stall_m", {PCSrc_M, RegWrite_M, MemWrite_M}, 3'b111);

        // Flush with a passing instruction, then flush together with stall
        Stall_E = 1'b0; Flush_E = 1'b1;
        drive(1'b1, 4'hE, 4'b0011, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check("flush_m", {PCSrc_M, RegWrite_M, MemWrite_M}, 3'b000);
        check("flush_flags", Flags, saved_flags);
        Flush_E = 1'b0;
        tick();
        Stall_E = 1'b1; Flush_E = 1'b1;
        tick();
        check("stall_flush_m", {PCSrc_M, RegWrite_M, MemWrite_M}, 3'b000);

        // Reset during a stall drops the stalled instruction
        Flush_E = 1'b0; nRESET = 1'b0;
        tick();
        check("reset_stall_flags", Flags, 4'b0000);
        nRESET = 1'b1; Stall_E = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            nRESET  = ($urandom_range(0, 49) != 0);
            Stall_E = ($urandom_range(0, 4) == 0);
            Flush_E = ($urandom_range(0, 7) == 0);
            drive_random();
            tick();
        end
        nRESET = 1'b1; Stall_E = 1'b0; Flush_E = 1'b0;

`ifdef COND_PERF_CNT_EN
        nRESET = 1'b0;
        tick();
        nRESET = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i % 3 == 1) ? 4'hF : 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 4) begin
                Stall_E = 1'b1;
                repeat (2) tick();
                Stall_E = 1'b0;
            end
            tick();
        end
        check("exec_total", ExecCount, 32'd5);
        check("skip_total", SkipCount, 32'd3);
        force dut.exec_count = 32'hFFFF_FFFF;
        force dut.skip_count = 32'hFFFF_FFFF;
        #1;
        release dut.exec_count;
        release dut.skip_count;
        m_exec = 32'hFFFF_FFFF; m_skip = 32'hFFFF_FFFF;
        drive(1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("exec_wrap", ExecCount, 32'd0);
        drive(1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("skip_wrap", SkipCount, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
